// File: rtl/orb_pkg.sv
// orb_pkg: shared constants, arbiter state type and round-robin pick helper
// for the orbital-frame RAM write path.
package orb_pkg;

   localparam int unsigned ORB_DW      = 12;
   localparam int unsigned ORB_AW      = 11;
   localparam int unsigned ORB_MAX_REQ = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_WRITE
   } arb_state_t;

   // First set bit of pend scanning p, p+1, ... mod n. Returns p if none set.
   function automatic logic [2:0] rr_pick(input logic [7:0] pend,
                                          input logic [2:0] p,
                                          input int unsigned n);
      logic [2:0]  win;
      logic        found;
      int unsigned j;
      win   = p;
      found = 1'b0;
      for (int unsigned k = 0; k < ORB_MAX_REQ; k++) begin
         j = (32'(p) + k) % n;
         if (!found && (k < n) && pend[j[2:0]]) begin
            win   = j[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/orb_ram_wr_arbiter_if.sv
// orb_ram_wr_arbiter_if: packer request bus and RAM write-port bus.
//  slave  : arbiter side (takes requests, drives RAM port, grant, busy, ovf)
//  master : packer/environment side
//  drop_cnt is present only when ORB_ARB_DROP_CNT_EN is defined.
interface orb_ram_wr_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned DW    = 12,
   parameter int unsigned AW    = 11
);
   logic [N_REQ-1:0]    req_we;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_data;
   logic                clr_ovf;
   logic                ram_we;
   logic [AW-1:0]       ram_addr;
   logic [DW-1:0]       ram_data;
   logic [N_REQ-1:0]    grant;
   logic                busy;
   logic [N_REQ-1:0]    ovf;
`ifdef ORB_ARB_DROP_CNT_EN
   logic [15:0]         drop_cnt;
`endif

   modport slave (
      input  req_we, req_addr, req_data, clr_ovf,
      output ram_we, ram_addr, ram_data, grant, busy, ovf
`ifdef ORB_ARB_DROP_CNT_EN
      , output drop_cnt
`endif
   );

   modport master (
      output req_we, req_addr, req_data, clr_ovf,
      input  ram_we, ram_addr, ram_data, grant, busy, ovf
`ifdef ORB_ARB_DROP_CNT_EN
      , input drop_cnt
`endif
   );

endinterface

// File: rtl/orb_req_slot.sv
// orb_req_slot: one requester's capture slot.
//  Ports: clk, rst (sync, active-high); req_we level, addr, data from the packer;
//  done = this slot's grant (last write cycle); clr_ovf clears the ovf flag.
//  Outputs: slot_addr/slot_data (held word), pend, ovf (sticky), drop_c (this-cycle drop).
module orb_req_slot
   import orb_pkg::*;
#(
   parameter int unsigned DW = ORB_DW,
   parameter int unsigned AW = ORB_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          done,
   input  logic          clr_ovf,
   output logic [AW-1:0] slot_addr,
   output logic [DW-1:0] slot_data,
   output logic          pend,
   output logic          ovf,
   output logic          drop_c
);

   logic prev;
   logic rise_c;

   assign rise_c = req_we & ~prev;
   // A completing slot frees itself this edge, so a coincident rise refills it.
   assign drop_c = rise_c & pend & ~done;

   // Edge history, slot contents, pending and overflow flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev      <= 1'b0;
         pend      <= 1'b0;
         ovf       <= 1'b0;
         slot_addr <= '0;
         slot_data <= '0;
      end else begin
         prev <= req_we;
         if (rise_c && (!pend || done)) begin
            slot_addr <= addr;
            slot_data <= data;
            pend      <= 1'b1;
         end else if (done) begin
            pend <= 1'b0;
         end
         // A new drop wins over a same-cycle clear.
         if (drop_c) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/orb_ram_wr_arbiter.sv
// orb_ram_wr_arbiter: round-robin sharing of the frame RAM write port among
// N_REQ word packers. Each request is captured in a slot and replayed as a
// WR_CYC-cycle ram_we pulse; back-to-back writes keep ram_we high.
//  Ports: clk, rst (sync, active-high); bus (slave modport) carrying
//  req_we/req_addr/req_data/clr_ovf in and ram_we/ram_addr/ram_data/grant/busy/ovf out.
//  Optional: ORB_ARB_DROP_CNT_EN adds bus.drop_cnt, a saturating count of dropped captures.
module orb_ram_wr_arbiter
   import orb_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DW     = ORB_DW,
   parameter int unsigned AW     = ORB_AW,
   parameter int unsigned WR_CYC = 2
) (
   input logic             clk,
   input logic             rst,
   orb_ram_wr_arbiter_if.slave bus
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(WR_CYC + 1);

   logic [N_REQ-1:0] pend;
   logic [N_REQ-1:0] ovf;
   logic [N_REQ-1:0] drop_c;
   logic [AW-1:0]    slot_addr [N_REQ];
   logic [DW-1:0]    slot_data [N_REQ];

   arb_state_t       state;
   logic [IW-1:0]    p;
   logic [IW-1:0]    w;
   logic [CW-1:0]    cnt;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [DW-1:0]    ram_data;
   logic [N_REQ-1:0] grant;
   logic             busy;

   logic [IW-1:0]    nxt_ptr_c;
   logic [N_REQ-1:0] pend_rest_c;
   logic [IW-1:0]    win_idle_c;
   logic [IW-1:0]    win_next_c;
   logic             last_c;

   // Per-requester capture slots; grant doubles as the slot's completion strobe.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
      orb_req_slot #(.DW(DW), .AW(AW)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .req_we    (bus.req_we[gi]),
         .addr      (bus.req_addr[gi*AW +: AW]),
         .data      (bus.req_data[gi*DW +: DW]),
         .done      (grant[gi]),
         .clr_ovf   (bus.clr_ovf),
         .slot_addr (slot_addr[gi]),
         .slot_data (slot_data[gi]),
         .pend      (pend[gi]),
         .ovf       (ovf[gi]),
         .drop_c    (drop_c[gi])
      );
   end

   // Winner selection: fresh pick in IDLE, and the follow-on pick at the end of
   // a write, which excludes the slot being retired this cycle.
   always_comb begin
      nxt_ptr_c   = (w == IW'(N_REQ - 1)) ? '0 : w + IW'(1);
      pend_rest_c = pend & ~grant;
      win_idle_c  = IW'(rr_pick(8'(pend), 3'(p), N_REQ));
      win_next_c  = IW'(rr_pick(8'(pend_rest_c), 3'(nxt_ptr_c), N_REQ));
      last_c      = (cnt == CW'(WR_CYC));
   end

   // Arbiter FSM with registered RAM port, grant and busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         p        <= '0;
         w        <= '0;
         cnt      <= '0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         grant    <= '0;
         busy     <= 1'b0;
      end else begin
         grant <= '0;
         case (state)
            ARB_IDLE: begin
               if (|pend) begin
                  w        <= win_idle_c;
                  ram_addr <= slot_addr[win_idle_c];
                  ram_data <= slot_data[win_idle_c];
                  ram_we   <= 1'b1;
                  busy     <= 1'b1;
                  cnt      <= CW'(1);
                  state    <= ARB_WRITE;
                  if (WR_CYC == 1) grant <= N_REQ'(1) << win_idle_c;
               end
            end
            ARB_WRITE: begin
               if (last_c) begin
                  p <= nxt_ptr_c;
                  if (|pend_rest_c) begin
                     // Back-to-back: ram_we stays high, address/data switch here.
                     w        <= win_next_c;
                     ram_addr <= slot_addr[win_next_c];
                     ram_data <= slot_data[win_next_c];
                     cnt      <= CW'(1);
                     if (WR_CYC == 1) grant <= N_REQ'(1) << win_next_c;
                  end else begin
                     ram_we <= 1'b0;
                     busy   <= 1'b0;
                     cnt    <= '0;
                     state  <= ARB_IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  // Grant is raised so it lines up with the final ram_we cycle.
                  if (cnt + CW'(1) == CW'(WR_CYC)) grant <= N_REQ'(1) << w;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.ram_we   = ram_we;
   assign bus.ram_addr = ram_addr;
   assign bus.ram_data = ram_data;
   assign bus.grant    = grant;
   assign bus.busy     = busy;
   assign bus.ovf      = ovf;

`ifdef ORB_ARB_DROP_CNT_EN
   logic [15:0] drop_cnt;
   logic [3:0]  drops_c;
   logic [16:0] sum_c;

   // Number of requesters dropping a capture this cycle.
   always_comb begin
      drops_c = '0;
      for (int i = 0; i < N_REQ; i++) begin
         drops_c = drops_c + 4'(drop_c[i]);
      end
      sum_c = 17'(drop_cnt) + 17'(drops_c);
   end

   // Saturating total; a clear keeps this cycle's drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (bus.clr_ovf) begin
         drop_cnt <= 16'(drops_c);
      end else begin
         drop_cnt <= sum_c[16] ? 16'hFFFF : sum_c[15:0];
      end
   end

   assign bus.drop_cnt = drop_cnt;
`else
   logic unused_drop_c;
   assign unused_drop_c = ^drop_c;
`endif

endmodule

// File: tb/tb_orb_ram_wr_arbiter.sv
// tb_orb_ram_wr_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a slot/queue-level reference model of the arbiter.
module tb_orb_ram_wr_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 12;
   localparam int unsigned AW  = 11;
   localparam int unsigned WRC = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   orb_ram_wr_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus ();

   orb_ram_wr_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .WR_CYC(WRC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: requester slots plus "current write, cycles left".
   bit            m_prev [N];
   bit            m_pend [N];
   logic [AW-1:0] m_sa   [N];
   logic [DW-1:0] m_sd   [N];
   bit            m_ovf  [N];
   int            m_p;
   bit            m_act;
   int            m_who;
   int            m_left;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_drop;

   // Observation tallies.
   int            g_hits [N];
   int            g_order[$];
   int            cur_run;
   int            max_run;
   logic [DW-1:0] last_data1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_pick(input int from, input int skip);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (from + k) % N;
         if (m_pend[j] && j != skip) return j;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
         m_sa[i] = '0; m_sd[i] = '0;
      end
      m_p = 0; m_act = 0; m_who = 0; m_left = 0;
      m_addr = '0; m_data = '0; m_drop = 0;
   endtask

   // Advance the model by one clock edge with the inputs now on the bus.
   task automatic m_step(input logic [N-1:0] we, input bit clr, input bit r);
      int g, w, dcnt;
      bit e, dn, drp;
      if (r) begin
         m_reset();
         return;
      end
      g = (m_act && m_left == 1) ? m_who : -1;
      if (m_act && m_left > 1) begin
         m_left--;
      end else begin
         if (g >= 0) m_p = (g + 1) % N;
         w = m_pick(m_p, g);
         if (w >= 0) begin
            m_act = 1; m_who = w; m_left = WRC;
            m_addr = m_sa[w]; m_data = m_sd[w];
         end else begin
            m_act = 0;
         end
      end
      dcnt = 0;
      for (int i = 0; i < N; i++) begin
         e   = we[i] && !m_prev[i];
         dn  = (i == g);
         drp = e && m_pend[i] && !dn;
         if (e && (!m_pend[i] || dn)) begin
            m_sa[i]   = bus.req_addr[i*AW +: AW];
            m_sd[i]   = bus.req_data[i*DW +: DW];
            m_pend[i] = 1;
         end else if (dn) begin
            m_pend[i] = 0;
         end
         if (drp) begin
            m_ovf[i] = 1;
            dcnt++;
         end else if (clr) begin
            m_ovf[i] = 0;
         end
         m_prev[i] = we[i];
      end
      if (clr) m_drop = dcnt;
      else     m_drop = (m_drop + dcnt > 65535) ? 65535 : m_drop + dcnt;
   endtask

   task automatic compare();
      logic [N-1:0] eg, eo;
      eg = '0;
      if (m_act && m_left == 1) eg[m_who] = 1'b1;
      for (int i = 0; i < N; i++) eo[i] = m_ovf[i];
      chk("ram_we", 32'(bus.ram_we), 32'(m_act));
      chk("busy",   32'(bus.busy),   32'(m_act));
      chk("grant",  32'(bus.grant),  32'(eg));
      chk("ovf",    32'(bus.ovf),    32'(eo));
      if (m_act) begin
         chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
         chk("ram_data", 32'(bus.ram_data), 32'(m_data));
      end
`ifdef ORB_ARB_DROP_CNT_EN
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`endif
   endtask

   task automatic clr_stats();
      for (int i = 0; i < N; i++) g_hits[i] = 0;
      g_order.delete();
      cur_run = 0;
      max_run = 0;
   endtask

   // Apply inputs at the falling edge, step the model, compare at the next falling edge.
   task automatic tick(input logic [N-1:0] we, input bit clr, input bit r);
      bus.req_we  = we;
      bus.clr_ovf = clr;
      rst         = r;
      m_step(we, clr, r);
      @(negedge clk);
      compare();
      for (int i = 0; i < N; i++) begin
         if (bus.grant[i]) begin
            g_hits[i]++;
            g_order.push_back(i);
            if (i == 1) last_data1 = bus.ram_data;
         end
      end
      cur_run = bus.ram_we ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
   endtask

   task automatic set_ad(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   initial begin
      logic [N-1:0] we;
      bit           seen;
      rst          = 1'b1;
      bus.req_we   = '1;
      bus.clr_ovf  = 1'b0;
      bus.req_addr = '0;
      bus.req_data = '0;
      m_reset();
      clr_stats();
      @(negedge clk);

      // 1: reset with all levels high, then one write per requester.
      for (int k = 0; k < 3; k++) tick(4'hF, 0, 1);
      chk("rst_ram_we", 32'(bus.ram_we), 32'(0));
      chk("rst_grant",  32'(bus.grant),  32'(0));
      chk("rst_ovf",    32'(bus.ovf),    32'(0));
      chk("rst_busy",   32'(bus.busy),   32'(0));
      for (int i = 0; i < N; i++) set_ad(i, AW'(16 + i), DW'(12'h010 + i));
      for (int k = 0; k < 14; k++) tick(4'hF, 0, 0);
      chk("held_writes", 32'(g_order.size()), 32'(4));
      for (int k = 0; k < 3; k++) tick(4'h0, 0, 0);

      // 3: contention from p=0, order 0..3, eight continuous ram_we cycles.
      clr_stats();
      for (int i = 0; i < N; i++) set_ad(i, AW'(32 * i + 1), DW'(12'h100 + i));
      tick(4'hF, 0, 0);
      for (int k = 0; k < 12; k++) tick(4'hF, 0, 0);
      chk("cont_run", 32'(max_run), 32'(8));
      chk("cont_cnt", 32'(g_order.size()), 32'(4));
      for (int k = 0; k < g_order.size() && k < 4; k++) chk("cont_order", 32'(g_order[k]), 32'(k));
      for (int k = 0; k < 3; k++) tick(4'h0, 0, 0);

      // 2: single request on requester 2.
      clr_stats();
      set_ad(2, 11'h155, 12'hABC);
      tick(4'b0100, 0, 0);
      chk("s_e0_we", 32'(bus.ram_we), 32'(0));
      tick(4'b0100, 0, 0);
      chk("s_c1_we",    32'(bus.ram_we),   32'(1));
      chk("s_c1_addr",  32'(bus.ram_addr), 32'(11'h155));
      chk("s_c1_data",  32'(bus.ram_data), 32'(12'hABC));
      chk("s_c1_grant", 32'(bus.grant),    32'(0));
      tick(4'b0100, 0, 0);
      chk("s_c2_we",    32'(bus.ram_we), 32'(1));
      chk("s_c2_grant", 32'(bus.grant),  32'(4'b0100));
      tick(4'b0000, 0, 0);
      chk("s_c3_we", 32'(bus.ram_we), 32'(0));
      for (int k = 0; k < 2; k++) tick(4'h0, 0, 0);

      // Move the pointer to 2 with a write on requester 1.
      tick(4'b0010, 0, 0);
      for (int k = 0; k < 5; k++) tick(4'h0, 0, 0);

      // 4: overflow on requester 1, queued behind 2,3,0.
      clr_stats();
      for (int i = 0; i < N; i++) set_ad(i, AW'(12'h200 + i), DW'(12'h300 + i));
      set_ad(1, 11'h0AA, 12'h5A5);
      tick(4'hF, 0, 0);
      tick(4'b1101, 0, 0);
      set_ad(1, 11'h0BB, 12'hB0B);
      tick(4'hF, 0, 0);
      for (int k = 0; k < 12; k++) tick(4'hF, 0, 0);
      chk("ovf_flag",  32'(bus.ovf),    32'(4'b0010));
      chk("ovf_word",  32'(last_data1), 32'(12'h5A5));
      chk("ovf_order", 32'(g_order.size() > 3 ? g_order[3] : -1), 32'(1));
`ifdef ORB_ARB_DROP_CNT_EN
      chk("drop_one", 32'(bus.drop_cnt), 32'(1));
`endif
      tick(4'h0, 1, 0);
      chk("ovf_clr", 32'(bus.ovf), 32'(0));
`ifdef ORB_ARB_DROP_CNT_EN
      chk("drop_clr", 32'(bus.drop_cnt), 32'(0));
`endif
      for (int k = 0; k < 2; k++) tick(4'h0, 0, 0);

      // 5: requester 3 re-edges on its grant cycle; both words written.
      clr_stats();
      set_ad(3, 11'h033, 12'h123);
      tick(4'b1000, 0, 0);
      tick(4'b0000, 0, 0);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (bus.grant == 4'b1000) seen = 1;
         else tick(4'b0000, 0, 0);
      end
      chk("refill_grant_seen", 32'(seen), 32'(1));
      set_ad(3, 11'h044, 12'hDEF);
      tick(4'b1000, 0, 0);
      for (int k = 0; k < 6; k++) tick(4'b1000, 0, 0);
      chk("refill_writes", 32'(g_hits[3]), 32'(2));
      chk("refill_ovf",    32'(bus.ovf[3]), 32'(0));
      for (int k = 0; k < 2; k++) tick(4'h0, 0, 0);

      // 6: reset during the first write cycle.
      clr_stats();
      set_ad(0, 11'h011, 12'h0EE);
      tick(4'b0001, 0, 0);
      tick(4'b0001, 0, 0);
      chk("mid_we_on", 32'(bus.ram_we), 32'(1));
      tick(4'b0001, 0, 1);
      chk("mid_we_off", 32'(bus.ram_we), 32'(0));
      for (int k = 0; k < 4; k++) tick(4'b0000, 0, 0);
      chk("mid_no_grant", 32'(g_hits[0]), 32'(0));
      chk("mid_idle_we",  32'(bus.ram_we), 32'(0));

      // Randomized traffic.
      we = '0;
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) we[i] = ~we[i];
            set_ad(i, AW'($urandom), DW'($urandom));
         end
         tick(we, $urandom_range(19) == 0, $urandom_range(199) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
